// File: rtl/hd_controller_if.sv
// Requester-side bus of the hard drive controller: two requesters packed side by side.
interface hd_controller_if #(
    parameter int LEN_W = 8
);
    logic [1:0]         req;
    logic [1:0]         req_write;
    logic [13:0]        req_track;
    logic [27:0]        req_sector;
    logic [2*LEN_W-1:0] req_len;
    logic [63:0]        wdata;
    logic [1:0]         grant;
    logic [1:0]         wready;
    logic [1:0]         rvalid;
    logic [31:0]        rdata;
    logic [1:0]         done;
    logic [1:0]         err;

    modport master (
        output req, req_write, req_track, req_sector, req_len, wdata,
        input  grant, wready, rvalid, rdata, done, err
    );

    modport slave (
        input  req, req_write, req_track, req_sector, req_len, wdata,
        output grant, wready, rvalid, rdata, done, err
    );
endinterface

// File: rtl/hd_controller.sv
// Round-robin burst sequencer between two requesters and the single-port hard drive.
// Each burst walks consecutive sectors, wrapping sector into track and track back to 0.
module hd_controller #(
    parameter int TRACKS  = 7,
    parameter int SECTORS = 14,
    parameter int LEN_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    hd_controller_if.slave bus,
    output logic [6:0]  track,
    output logic [13:0] sector,
    output logic [31:0] data_write,
    output logic        flag_write_hd,
    input  logic [31:0] output_hard_drive
);
    localparam logic [6:0]  TRK_LIM = 7'(TRACKS);
    localparam logic [6:0]  TRK_MAX = 7'(TRACKS - 1);
    localparam logic [13:0] SEC_LIM = 14'(SECTORS);
    localparam logic [13:0] SEC_MAX = 14'(SECTORS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t             state, nxt;
    logic               owner, last, dir_wr;
    logic [6:0]         cur_trk;
    logic [13:0]        cur_sec;
    logic [LEN_W-1:0]   cnt;
    logic [1:0]         err_r, rvalid_r, oh;
    logic [31:0]        rdata_r;

    // winner's request fields, muxed before any validation
    logic               win, w_wr, w_bad;
    logic [6:0]         w_trk;
    logic [13:0]        w_sec;
    logic [LEN_W-1:0]   w_len;

    assign oh         = owner ? 2'b10 : 2'b01;
    assign bus.err    = err_r;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;

    // State register; reset abandons any burst in progress
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // Arbitration, request validation, next state and hard drive port decode
    always_comb begin
        win           = 1'b0;
        nxt           = state;
        bus.grant     = '0;
        bus.wready    = '0;
        bus.done      = '0;
        track         = '0;
        sector        = '0;
        data_write    = '0;
        flag_write_hd = 1'b0;
        case (bus.req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        w_wr  = win ? bus.req_write[1]            : bus.req_write[0];
        w_trk = win ? bus.req_track[13:7]         : bus.req_track[6:0];
        w_sec = win ? bus.req_sector[27:14]       : bus.req_sector[13:0];
        w_len = win ? bus.req_len[2*LEN_W-1:LEN_W] : bus.req_len[LEN_W-1:0];
        w_bad = (w_trk >= TRK_LIM) || (w_sec >= SEC_LIM) || (w_len == '0);
        case (state)
            IDLE:    if (|bus.req && !w_bad) nxt = XFER;
            XFER:    if (cnt == LEN_W'(1)) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (state == XFER) begin
            bus.grant = oh;
            track     = cur_trk;
            sector    = cur_sec;
            if (dir_wr) begin
                bus.wready    = oh;
                flag_write_hd = 1'b1;
                data_write    = owner ? bus.wdata[63:32] : bus.wdata[31:0];
            end
        end
        if (state == DONE) bus.done = oh;
    end

    // Burst context: latch on grant, advance address and count per word, capture read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            dir_wr   <= 1'b0;
            cur_trk  <= '0;
            cur_sec  <= '0;
            cnt      <= '0;
            err_r    <= '0;
            rvalid_r <= '0;
            rdata_r  <= '0;
        end else begin
            err_r    <= '0;
            rvalid_r <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    last <= win;
                    if (w_bad) begin
                        err_r <= win ? 2'b10 : 2'b01;
                    end else begin
                        owner   <= win;
                        dir_wr  <= w_wr;
                        cur_trk <= w_trk;
                        cur_sec <= w_sec;
                        cnt     <= w_len;
                    end
                end
                XFER: begin
                    cnt <= cnt - LEN_W'(1);
                    if (cur_sec == SEC_MAX) begin
                        cur_sec <= '0;
                        cur_trk <= (cur_trk == TRK_MAX) ? '0 : cur_trk + 7'd1;
                    end else begin
                        cur_sec <= cur_sec + 14'd1;
                    end
                    if (!dir_wr) begin
                        rdata_r  <= output_hard_drive;
                        rvalid_r <= oh;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hd_controller.sv
// Directed bench: a transaction-level model expands each request into a per-cycle
// timeline of expected outputs, checked every cycle; literal checks pin the model.
module tb_hd_controller;
    localparam int NT = 7;
    localparam int NS = 14;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  hd_track;
    logic [13:0] hd_sector;
    logic [31:0] hd_data_write, hd_out;
    logic        hd_we;
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    hd_controller_if #(.LEN_W(8)) bus();

    hd_controller #(.TRACKS(NT), .SECTORS(NS), .LEN_W(8)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .track(hd_track), .sector(hd_sector), .data_write(hd_data_write),
        .flag_write_hd(hd_we), .output_hard_drive(hd_out)
    );

    // Hard drive: combinational read, write on the clock edge
    logic [31:0] hd_mem [NT][NS];
    always @(posedge clock) if (hd_we) hd_mem[hd_track][hd_sector] <= hd_data_write;
    assign hd_out = (hd_track < 7'(NT) && hd_sector < 14'(NS)) ? hd_mem[hd_track][hd_sector] : 32'h0;

    function automatic logic [31:0] init_word(int t, int s);
        return 32'hC0DE0000 + 32'(t * 256 + s);
    endfunction

    // Expected timeline, keyed by cycle number; missing entries mean 0
    logic [1:0]  e_grant[int], e_wready[int], e_rvalid[int], e_done[int], e_err[int];
    logic [6:0]  e_trk[int];
    logic [13:0] e_sec[int];
    logic [31:0] e_dw[int], e_rd[int];
    logic        e_fw[int];
    logic [31:0] wd_sched[int];
    int          wd_who[int];
    logic [31:0] shadow [NT][NS];
    logic [31:0] wq[$];
    logic [31:0] rd_log[$];
    logic [20:0] addr_log[$];
    int          err_cnt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Expand one request into expected per-cycle outputs; cycles after 'cut' never happen
    task automatic predict(int i, bit wr, int t, int s, int len, int T, int cut);
        logic [1:0] oh;
        oh = (i == 1) ? 2'b10 : 2'b01;
        if (t >= NT || s >= NS || len == 0) begin
            e_err[T+1] = oh;
            return;
        end
        for (int k = 1; k <= len; k++) begin
            int c;
            c = T + k;
            if (c > cut) break;
            e_grant[c] = oh;
            e_trk[c]   = 7'(t);
            e_sec[c]   = 14'(s);
            if (wr) begin
                e_wready[c] = oh;
                e_fw[c]     = 1'b1;
                e_dw[c]     = wq[k-1];
                wd_sched[c] = wq[k-1];
                wd_who[c]   = i;
                shadow[t][s] = wq[k-1];
            end else begin
                e_rvalid[c+1] = oh;
                e_rd[c+1]     = shadow[t][s];
            end
            s++;
            if (s == NS) begin
                s = 0;
                t++;
                if (t == NT) t = 0;
            end
        end
        if (T + len + 1 <= cut) e_done[T+len+1] = oh;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_req(int i, bit wr, int t, int s, int len);
        bus.req[i]                 = 1'b1;
        bus.req_write[i]           = wr;
        bus.req_track[i*7 +: 7]    = 7'(t);
        bus.req_sector[i*14 +: 14] = 14'(s);
        bus.req_len[i*8 +: 8]      = 8'(len);
    endtask

    // Single request held for one IDLE cycle, then wait until the controller is idle again
    task automatic issue(int i, bit wr, int t, int s, int len);
        int T;
        T = cyc;
        set_req(i, wr, t, s, len);
        predict(i, wr, t, s, len, T, 1 << 30);
        wait_cyc(T + 1);
        bus.req[i] = 1'b0;
        if (t >= NT || s >= NS || len == 0) wait_cyc(T + 2);
        else                                wait_cyc(T + len + 2);
    endtask

    // Requester write-data driver; the idle requester shows a decoy word
    always @(posedge clock) begin
        #1;
        if (wd_sched.exists(cyc)) begin
            bus.wdata[wd_who[cyc]*32 +: 32]       = wd_sched[cyc];
            bus.wdata[(1-wd_who[cyc])*32 +: 32]   = ~wd_sched[cyc];
        end else begin
            bus.wdata = 64'h0BAD_F00D_DEAD_BEEF;
        end
    end

    // Every-cycle compare against the expected timeline
    always @(negedge clock) begin
        chk("grant",  64'(bus.grant),  64'(e_grant.exists(cyc)  ? e_grant[cyc]  : 2'b0));
        chk("wready", 64'(bus.wready), 64'(e_wready.exists(cyc) ? e_wready[cyc] : 2'b0));
        chk("rvalid", 64'(bus.rvalid), 64'(e_rvalid.exists(cyc) ? e_rvalid[cyc] : 2'b0));
        chk("done",   64'(bus.done),   64'(e_done.exists(cyc)   ? e_done[cyc]   : 2'b0));
        chk("err",    64'(bus.err),    64'(e_err.exists(cyc)    ? e_err[cyc]    : 2'b0));
        chk("track",  64'(hd_track),   64'(e_trk.exists(cyc)    ? e_trk[cyc]    : 7'b0));
        chk("sector", 64'(hd_sector),  64'(e_sec.exists(cyc)    ? e_sec[cyc]    : 14'b0));
        chk("we",     64'(hd_we),      64'(e_fw.exists(cyc)     ? e_fw[cyc]     : 1'b0));
        chk("wdata",  64'(hd_data_write), 64'(e_dw.exists(cyc)  ? e_dw[cyc]     : 32'b0));
        if (e_rd.exists(cyc)) chk("rdata", 64'(bus.rdata), 64'(e_rd[cyc]));
        if (bus.rvalid != 2'b0) rd_log.push_back(bus.rdata);
        if (bus.grant != 2'b0)  addr_log.push_back({hd_track, hd_sector});
        if (bus.err != 2'b0)    err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: cycle %0d, run did not complete", cyc);
        $fatal(1);
    end

    initial begin
        int T, R;
        for (int t = 0; t < NT; t++)
            for (int s = 0; s < NS; s++) begin
                hd_mem[t][s] = init_word(t, s);
                shadow[t][s] = init_word(t, s);
            end
        bus.req = '0; bus.req_write = '0; bus.req_track = '0;
        bus.req_sector = '0; bus.req_len = '0; bus.wdata = '0;
        #1 reset = 1'b0;
        wait_cyc(2);
        chk("rst_grant", 64'(bus.grant), 64'h0);
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        chk("rst_we",    64'(hd_we),     64'h0);
        reset = 1'b1;
        R = cyc;

        // Round-robin tie: both held, len 1 reads -> owners 0,1,0,1
        wait_cyc(R + 1);
        T = cyc;
        set_req(0, 1'b0, 2, 0, 1);
        set_req(1, 1'b0, 2, 1, 1);
        predict(0, 1'b0, 2, 0, 1, T,     1 << 30);
        predict(1, 1'b0, 2, 1, 1, T + 3, 1 << 30);
        predict(0, 1'b0, 2, 0, 1, T + 6, 1 << 30);
        predict(1, 1'b0, 2, 1, 1, T + 9, 1 << 30);
        wait_cyc(T + 4);
        chk("tie_second_grant", 64'(bus.grant), 64'h2);
        wait_cyc(T + 10);
        bus.req = '0;
        wait_cyc(T + 12);
        chk("tie_rdata_lit", 64'(rd_log.size() == 4 ? rd_log[1] : 32'h0), 64'hC0DE0201);

        // Write burst crossing the sector wrap
        wq = {32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
        issue(0, 1'b1, 0, 12, 3);
        chk("wr_mem_1_0", 64'(hd_mem[1][0]),  64'hAAAA0003);
        chk("wr_mem_0_13", 64'(hd_mem[0][13]), 64'hAAAA0002);

        // Read the same words back through requester 1
        rd_log.delete();
        issue(1, 1'b0, 0, 12, 3);
        chk("rb_count", 64'(rd_log.size()), 64'd3);
        if (rd_log.size() == 3) begin
            chk("rb_w0", 64'(rd_log[0]), 64'hAAAA0001);
            chk("rb_w2", 64'(rd_log[2]), 64'hAAAA0003);
        end

        // End-of-drive wrap
        addr_log.delete();
        issue(0, 1'b0, 6, 13, 2);
        chk("wrap_a0", 64'(addr_log.size() > 0 ? addr_log[0] : 21'h0), 64'({7'd6, 14'd13}));
        chk("wrap_a1", 64'(addr_log.size() > 1 ? addr_log[1] : 21'h1FFFFF), 64'h0);

        // Rejects: bad track, bad sector, zero length
        err_cnt = 0;
        issue(0, 1'b1, 7, 0, 1);
        issue(0, 1'b1, 0, 14, 1);
        issue(0, 1'b1, 0, 0, 0);
        chk("err_pulses", 64'(err_cnt), 64'd3);

        // Reset after two of four words commit
        wq = {32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 32'hBBBB0004};
        T = cyc;
        set_req(0, 1'b1, 3, 0, 4);
        predict(0, 1'b1, 3, 0, 4, T, T + 2);
        wait_cyc(T + 1);
        bus.req = '0;
        wait_cyc(T + 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_we",    64'(hd_we),     64'h0);
        chk("mid_rst_grant", 64'(bus.grant), 64'h0);
        wait_cyc(T + 5);
        reset = 1'b1;
        wait_cyc(T + 6);
        rd_log.delete();
        issue(1, 1'b0, 3, 0, 4);
        chk("rst_rb_count", 64'(rd_log.size()), 64'd4);
        if (rd_log.size() == 4) begin
            chk("rst_rb_w1", 64'(rd_log[1]), 64'hBBBB0002);
            chk("rst_rb_w2", 64'(rd_log[2]), 64'hC0DE0302);
            chk("rst_rb_w3", 64'(rd_log[3]), 64'hC0DE0303);
        end

        wait_cyc(cyc + 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hd_controller.md
# hd_controller

Sequencing and arbitration controller for the single-port track/sector hard drive store. Two requesters (0: CPU memory stage, 1: OS loader) issue multi-word burst reads or writes. The controller grants them round-robin, walks consecutive track/sector addresses with wrap-around, and drives the hard drive's address, data and write-enable ports. It sits between the requesters and `harddrive`; the hard drive read path is combinational, and its write commits on the clock edge.

## Interface
- TRACKS, 7, number of valid tracks (0..TRACKS-1)
- SECTORS, 14, number of valid sectors per track (0..SECTORS-1)
- LEN_W, 8, width of burst length field
- clock  input  1  system clock, rising edge
- reset  input  1  reset; asynchronous, active-low
- req  input  2  request per requester; bit i = requester i
- req_write  input  2  1 = burst write, 0 = burst read
- req_track  input  14  start track; [6:0] = req0, [13:7] = req1
- req_sector  input  28  start sector; [13:0] = req0, [27:14] = req1
- req_len  input  2*LEN_W  word count per requester, packed as above
- wdata  input  64  write data; [31:0] = req0, [63:32] = req1
- grant  output  2  one-hot; high for the whole burst of the owner
- wready  output  2  owner must present its wdata word this cycle
- rvalid  output  2  rdata holds a valid word for requester i
- rdata  output  32  registered read data, shared
- done  output  2  1-cycle pulse after the last word of a burst
- err  output  2  1-cycle pulse; request rejected
- track  output  7  to hard drive
- sector  output  14  to hard drive
- data_write  output  32  to hard drive
- flag_write_hd  output  1  to hard drive write enable
- output_hard_drive  input  32  from hard drive, combinational read

## Operation
- States are IDLE, XFER and DONE.
- **IDLE:** sample `req`.
  - If both requesters are active, grant the one not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - If the winner's start track ≥ TRACKS, its start sector ≥ SECTORS, or its length is 0: pulse `err[i]` the next cycle, make no hard drive access, update the pointer, and stay in IDLE.
  - Otherwise latch direction, address and length, set `grant[i]`, and go to XFER.
- **XFER:** one word per cycle; `track`/`sector` = current address.
  - Write: `wready[i]`=1, `flag_write_hd`=1, `data_write` = requester i's wdata.
  - Read: `flag_write_hd`=0; `output_hard_drive` is registered into `rdata` and `rvalid[i]` is set the next cycle.
  - Address increment: sector+1. At SECTORS-1 the sector wraps to 0 and the track increments. At (TRACKS-1, SECTORS-1) the address wraps to (0,0).
  - Remaining count decrements each cycle. On the last word, go to DONE.
- **DONE:** `done[i]`=1 and `grant` drops to 0. Next state is IDLE.
- `req` is sampled only in IDLE. Changes to `req` or other request fields during XFER are ignored, and a burst always completes.
- A requester still holding `req` in the IDLE cycle after `done` starts a new burst. Requesters must drop `req` on seeing `done`.
- When not in XFER: `track`=0, `sector`=0, `data_write`=0, `flag_write_hd`=0.
- `flag_write_hd` is decoded from state and direction, with no extra register.

## Timing
- Reset (asynchronous): state=IDLE, pointer=1, all outputs 0. `flag_write_hd` falls immediately, and a burst in progress is abandoned.
- Request to first word: `req` high in IDLE cycle T gives `grant` and the first address in cycle T+1.
- Write burst of N words: occupies cycles T+1..T+N. Each word commits at the end of its cycle. `done` in T+N+1.
- Read burst of N words: addresses in T+1..T+N. `rvalid`/`rdata` in T+2..T+N+1. `done` in T+N+1, concurrent with the last `rvalid`.
- Rejected request: `err` in T+1, IDLE again at T+1. The next request is sampled in T+1.
- Back-to-back bursts: the minimum gap is one IDLE cycle after DONE.
- Maximum burst length is 2^LEN_W-1 words. A burst of TRACKS*SECTORS words or more rewrites or rereads wrapped addresses in order.

## Test plan
- **Write burst with sector wrap:** req0 write, track 0, sector 12, len 3, words AAAA0001..AAAA0003 → addresses (0,12),(0,13),(1,0) in 3 cycles with `wready[0]`, then `done[0]`.
- **Read-back:** req1 read of the same 3 words → `rvalid[1]` 3 cycles with `rdata` AAAA0001, AAAA0002, AAAA0003; `done[1]` with the last word.
- **Round-robin ties:** both req held, len 1 each, out of reset → grants 0,1,0,1 with one IDLE cycle between bursts.
- **End-of-drive wrap:** req0 read, track 6, sector 13, len 2 → addresses (6,13) then (0,0).
- **Rejects:**
  - track 7 → `err[0]`, no `flag_write_hd`, no `grant`.
  - sector 14 → same.
  - len 0 → same.
- **Reset mid-burst:** reset low during cycle 2 of a 4-word write → `flag_write_hd`/`grant` drop immediately, and words 3–4 are unwritten (verified by a read after reset).
